dmem_store_buffer: RTL and testbench

//  Posted-write buffer between the single-cycle core data port and a slower data memory.

---
 rtl/dmem_store_buffer_pkg.sv | 13 +
 rtl/sb_fwd_merge.sv | 34 +++
 rtl/dmem_store_buffer.sv | 108 ++++++++++
 tb/tb_dmem_store_buffer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer: the buffered store entry and default sizing.
package dmem_sb_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_AW            = 32;

    typedef struct packed {
        logic [SB_AW-3:0] waddr;
        logic [31:0]      data;
        logic [3:0]       strb;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-lane load forwarding: each byte comes from the newest valid matching entry, else from memory.
module sb_fwd_merge
    import dmem_sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  sb_entry_t                  entries_i [DEPTH],
    input  logic [DEPTH-1:0]           valid_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    input  logic [SB_AW-3:0]           lookup_waddr_i,
    input  logic [31:0]                mem_rd_data_i,
    output logic [31:0]                read_data_o
);

    localparam int IW = $clog2(DEPTH);

    // Walk oldest to newest so that later (younger) matches overwrite earlier ones.
    always_comb begin
        logic [IW-1:0] idx;
        read_data_o = mem_rd_data_i;
        idx         = rd_idx_i;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_idx_i + IW'(i);
            if (valid_i[idx] && (entries_i[idx].waddr == lookup_waddr_i)) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries_i[idx].strb[b]) begin
                        read_data_o[8*b +: 8] = entries_i[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the core data port and a slower data memory, with load forwarding.
module dmem_store_buffer
    import dmem_sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] ALUResult,
    input  logic [31:0]   WriteData,
    input  logic [3:0]    MemWriteByte,
    output logic [31:0]   ReadData,
    output logic          Stall,
    output logic          Empty,
    input  logic [31:0]   MemRdData,
    output logic          MemWvalid,
    input  logic          MemWready,
    output logic [AW-1:0] MemWaddr,
    output logic [31:0]   MemWdata,
    output logic [3:0]    MemWstrb
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    sb_entry_t        entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             full, empty, store_req, do_enq, do_deq;
    sb_entry_t        head, new_entry;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^ALUResult[1:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count  = wr_ptr_q - rd_ptr_q;
    assign full   = (count == PW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_idx = wr_ptr_q[IW-1:0];
    assign rd_idx = rd_ptr_q[IW-1:0];

    assign store_req = MemWrite && (MemWriteByte != 4'b0000);
    assign do_enq    = store_req && !full;
    assign do_deq    = !empty && MemWready;

    assign new_entry.waddr = ALUResult[AW-1:2];
    assign new_entry.data  = WriteData;
    assign new_entry.strb  = MemWriteByte;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (do_deq) begin
            rd_ptr_d        = rd_ptr_q + PW'(1);
            valid_d[rd_idx] = 1'b0;
        end
        if (do_enq) begin
            wr_ptr_d        = wr_ptr_q + PW'(1);
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage is payload only; occupancy lives in valid_q and the pointers.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            entries_q[wr_idx] <= new_entry;
        end
    end

    assign head = entries_q[rd_idx];

    assign MemWvalid = !empty;
    assign Empty     = empty;
    assign Stall     = store_req && full;
    assign MemWaddr  = MemWvalid ? {head.waddr, 2'b00} : '0;
    assign MemWdata  = MemWvalid ? head.data : '0;
    assign MemWstrb  = MemWvalid ? head.strb : '0;

    sb_fwd_merge #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries_i      (entries_q),
        .valid_i        (valid_q),
        .rd_idx_i       (rd_idx),
        .lookup_waddr_i (ALUResult[AW-1:2]),
        .mem_rd_data_i  (MemRdData),
        .read_data_o    (ReadData)
    );

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed and random stimulus for dmem_store_buffer against a queue-based store/memory model.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  strb;
    } m_ent_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic        MemWrite     = 1'b0;
    logic [31:0] ALUResult    = '0;
    logic [31:0] WriteData    = '0;
    logic [3:0]  MemWriteByte = '0;
    logic [31:0] MemRdData    = '0;
    logic        MemWready    = 1'b0;
    logic [31:0] ReadData;
    logic        Stall, Empty, MemWvalid;
    logic [31:0] MemWaddr, MemWdata;
    logic [3:0]  MemWstrb;

    always #5 clk = ~clk;

    dmem_store_buffer #(
        .DEPTH (DEPTH),
        .AW    (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .MemWriteByte (MemWriteByte),
        .ReadData     (ReadData),
        .Stall        (Stall),
        .Empty        (Empty),
        .MemRdData    (MemRdData),
        .MemWvalid    (MemWvalid),
        .MemWready    (MemWready),
        .MemWaddr     (MemWaddr),
        .MemWdata     (MemWdata),
        .MemWstrb     (MemWstrb)
    );

    // ---------------- scoreboard / model ----------------
    m_ent_t      exp_q[$];
    logic [31:0] bmem [logic [29:0]];
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          exp_stall = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic [3:0]  prev_strb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bmem_rd(input logic [29:0] k);
        if (bmem.exists(k)) return bmem[k];
        return {2'b10, k};
    endfunction

    function automatic void commit(input m_ent_t e);
        logic [31:0] w;
        w = bmem_rd(e.waddr);
        for (int b = 0; b < 4; b++)
            if (e.strb[b]) w[8*b +: 8] = e.data[8*b +: 8];
        bmem[e.waddr] = w;
    endfunction

    function automatic logic [31:0] exp_read(input logic [29:0] wa, input logic [31:0] base);
        logic [31:0] r;
        r = base;
        foreach (exp_q[i])
            if (exp_q[i].waddr == wa)
                for (int b = 0; b < 4; b++)
                    if (exp_q[i].strb[b]) r[8*b +: 8] = exp_q[i].data[8*b +: 8];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: check outputs at negedge against the model, then advance the model at posedge.
    task automatic step();
        bit ev, sreq, enq, deq;
        m_ent_t e;
        MemRdData = bmem_rd(ALUResult[31:2]);
        @(negedge clk);
        ev        = (exp_q.size() != 0);
        sreq      = MemWrite && (MemWriteByte != 4'b0000);
        exp_stall = sreq && (exp_q.size() == DEPTH);
        chk("wvalid", 32'(MemWvalid), 32'(ev));
        chk("empty", 32'(Empty), 32'(!ev));
        chk("stall", 32'(Stall), 32'(exp_stall));
        chk("rdata", ReadData, exp_read(ALUResult[31:2], MemRdData));
        if (ev) begin
            chk("waddr", MemWaddr, {exp_q[0].waddr, 2'b00});
            chk("wdata", MemWdata, exp_q[0].data);
            chk("wstrb", 32'(MemWstrb), 32'(exp_q[0].strb));
        end
        if (prev_hold) begin
            chk("hold_addr", MemWaddr, prev_addr);
            chk("hold_data", MemWdata, prev_data);
            chk("hold_strb", 32'(MemWstrb), 32'(prev_strb));
        end
        prev_hold = ev && !MemWready;
        prev_addr = MemWaddr;
        prev_data = MemWdata;
        prev_strb = MemWstrb;
        @(posedge clk);
        enq = sreq && (exp_q.size() < DEPTH);
        deq = ev && MemWready;
        if (deq) begin
            commit(exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (enq) begin
            e.waddr = ALUResult[31:2];
            e.data  = WriteData;
            e.strb  = MemWriteByte;
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic store_once(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        MemWrite = 1'b1; ALUResult = a; WriteData = d; MemWriteByte = s;
        step();
        MemWrite = 1'b0; MemWriteByte = 4'b0000;
    endtask

    task automatic idle(input int n, input logic rdy);
        MemWrite = 1'b0; MemWriteByte = 4'b0000; MemWready = rdy;
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous assertion a little after the edge, synchronous-style release at the negedge.
    task automatic do_reset();
        MemWrite = 1'b0; MemWriteByte = 4'b0000;
        #2 reset = 1'b0;
        #1;
        chk("rst_wvalid", 32'(MemWvalid), 32'(0));
        chk("rst_empty", 32'(Empty), 32'(1));
        chk("rst_stall", 32'(Stall), 32'(0));
        exp_q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int guard;
        @(posedge clk); #1;
        do_reset();

        // Single store drains the following cycle.
        MemWready = 1'b0;
        store_once(32'h100, 32'hDEADBEEF, 4'b1111);
        MemWready = 1'b1; #1;
        chk("t2_valid", 32'(MemWvalid), 32'(1));
        chk("t2_addr", MemWaddr, 32'h100);
        chk("t2_data", MemWdata, 32'hDEADBEEF);
        chk("t2_strb", 32'(MemWstrb), 32'(4'b1111));
        idle(1, 1'b1);
        chk("t2_empty", 32'(Empty), 32'(1));

        // Reset mid-drain discards pending stores.
        MemWready = 1'b0;
        for (int i = 0; i < 3; i++) store_once(32'h600 + 4*i, 32'h600 + i, 4'b1111);
        do_reset();
        idle(4, 1'b1);
        chk("t1_empty", 32'(Empty), 32'(1));

        // Full buffer stalls the fifth store until one entry drains.
        MemWready = 1'b0;
        for (int i = 0; i < 4; i++) store_once(32'h300 + 4*i, 32'hA0 + i, 4'b1111);
        MemWrite = 1'b1; ALUResult = 32'h310; WriteData = 32'hA4; MemWriteByte = 4'b1111; #1;
        chk("t3_stall", 32'(Stall), 32'(1));
        chk("t3_head", MemWdata, 32'hA0);
        step();
        MemWready = 1'b1;
        step();
        MemWready = 1'b0;
        step();
        chk("t3_enq", 32'(exp_stall), 32'(0));
        MemWrite = 1'b0; MemWriteByte = 4'b0000; MemWready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1 chk("t3_order", MemWdata, 32'hA0 + k);
            step();
        end
        chk("t3_empty", 32'(Empty), 32'(1));

        // Merge of two partial stores over memory data.
        MemWready = 1'b0;
        bmem[30'h80] = 32'h55667788;
        store_once(32'h203, 32'hAA000000, 4'b1000);
        store_once(32'h200, 32'h00001234, 4'b0011);
        ALUResult = 32'h200; MemRdData = bmem_rd(30'h80); #1;
        chk("t4_merge", ReadData, 32'hAA661234);
        step();

        // Newest entry wins per lane; after drain memory alone supplies data.
        store_once(32'h40, 32'h11111111, 4'b1111);
        store_once(32'h40, 32'h00000022, 4'b0001);
        ALUResult = 32'h40; MemRdData = bmem_rd(30'h10); #1;
        chk("t5_newest", ReadData, 32'h11111122);
        idle(6, 1'b1);
        ALUResult = 32'h40; MemRdData = bmem_rd(30'h10); #1;
        chk("t5_drained", ReadData, MemRdData);
        chk("t5_mem", ReadData, 32'h11111122);

        // Enqueue and dequeue in the same cycle with one entry pending.
        MemWready = 1'b0;
        store_once(32'h500, 32'h1, 4'b1111);
        MemWready = 1'b1;
        store_once(32'h504, 32'h2, 4'b1111);
        MemWready = 1'b0; #1;
        chk("t6_one_valid", 32'(MemWvalid), 32'(1));
        chk("t6_one_data", MemWdata, 32'h2);
        step();
        idle(1, 1'b1);
        chk("t6_one_empty", 32'(Empty), 32'(1));

        // Zero-strobe store while full is a no-op.
        MemWready = 1'b0;
        for (int i = 0; i < 4; i++) store_once(32'h700 + 4*i, 32'h70 + i, 4'b0101);
        MemWrite = 1'b1; ALUResult = 32'h720; WriteData = 32'hFF; MemWriteByte = 4'b0000; #1;
        chk("t6_nostall", 32'(Stall), 32'(0));
        step();
        idle(4, 1'b1);
        chk("t6_drain4", 32'(Empty), 32'(1));

        // Random traffic; a stalled store is re-presented unchanged.
        guard = 0;
        for (int n = 0; n < 400; n++) begin
            if (!exp_stall) begin
                MemWrite     = ($urandom_range(0, 99) < 60);
                ALUResult    = 32'h40 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                WriteData    = $urandom;
                MemWriteByte = 4'($urandom_range(0, 15));
                guard        = 0;
            end else begin
                guard++;
                chk("rand_stall_bound", 32'(guard < 50), 32'(1));
                if (guard >= 50) exp_stall = 1'b0;
            end
            MemWready = ($urandom_range(0, 99) < 40);
            step();
        end
        idle(DEPTH + 2, 1'b1);
        chk("final_empty", 32'(Empty), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
